// File: rtl/bsg_manycore_pod_reset_sequencer.sv
// bsg_manycore_pod_reset_sequencer: prompt per-pod reset assertion, staggered fixed-priority
// release, and a retimed per-tile-column reset fanout.
module bsg_manycore_pod_reset_sequencer #(
  parameter int num_pods_x_p     = 2,
  parameter int num_pods_y_p     = 2,
  parameter int num_tiles_x_p    = 4,
  parameter int reset_depth_p    = 3,
  parameter int stagger_cycles_p = 4
) (
  input  logic                                                          clk_i,
  input  logic                                                          reset_i,
  input  logic [num_pods_y_p-1:0][num_pods_x_p-1:0]                     reset_req_i,
  output logic [num_pods_y_p-1:0][num_pods_x_p-1:0][num_tiles_x_p-1:0]  reset_o,
  output logic [num_pods_y_p-1:0][num_pods_x_p-1:0]                     pod_in_reset_o,
  output logic                                                          busy_o
);
  localparam int N  = num_pods_x_p * num_pods_y_p;
  localparam int W  = N * num_tiles_x_p;
  localparam int CW = stagger_cycles_p > 1 ? $clog2(stagger_cycles_p) : 1;
  localparam logic [CW-1:0] GAP = CW'(stagger_cycles_p - 1);
  typedef enum logic {eIDLE, eGAP} state_e;
  logic [N-1:0]  r_rst, w_req, w_elig, w_grant;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_fan;
  state_e        w_state;
  assign w_req   = reset_req_i;
  assign w_state = r_cnt != '0 ? eGAP : eIDLE;
  assign w_elig  = r_rst & ~w_req;
  // Isolate the lowest set eligible bit: pod 0 has the highest priority.
  assign w_grant = w_state == eIDLE ? w_elig & (~w_elig + N'(1)) : '0;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      r_rst <= '1;
      r_cnt <= '0;
    end else begin
      r_rst <= (r_rst & ~w_grant) | w_req;
      r_cnt <= w_grant != '0 ? GAP : w_state == eGAP ? r_cnt - CW'(1) : r_cnt;
    end
  for (genvar p = 0; p < N; p++) begin : g_fan
    assign w_fan[p*num_tiles_x_p +: num_tiles_x_p] = {num_tiles_x_p{r_rst[p]}};
  end
  if (reset_depth_p == 1) begin : g_direct
    assign reset_o = w_fan;
  end else begin : g_pipe
    logic [reset_depth_p-2:0][W-1:0] r_pipe;
    always_ff @(posedge clk_i)
      if (reset_i) r_pipe <= '1;
      else begin
        r_pipe[0] <= w_fan;
        for (int i = 1; i < reset_depth_p - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    assign reset_o = r_pipe[reset_depth_p-2];
  end
  assign pod_in_reset_o = r_rst;
  assign busy_o         = w_state == eGAP;
endmodule

// File: tb/tb_bsg_manycore_pod_reset_sequencer.sv
// tb_bsg_manycore_pod_reset_sequencer: vector table, directed corner sequences and random
// stimulus against a release-time reference model, for stagger 4/depth 3 and stagger 1/depth 1.
module tb_bsg_manycore_pod_reset_sequencer;
  logic clk = 0;
  logic rst_in = 1;
  logic [1:0][1:0] req = '0;
  logic [1:0][1:0][3:0] ro_a, ro_b;
  logic [1:0][1:0] pir_a, pir_b;
  logic busy_a, busy_b;
  always #5 clk = ~clk;

  bsg_manycore_pod_reset_sequencer #(.num_pods_x_p(2), .num_pods_y_p(2), .num_tiles_x_p(4),
    .reset_depth_p(3), .stagger_cycles_p(4)) u_a (.clk_i(clk), .reset_i(rst_in),
    .reset_req_i(req), .reset_o(ro_a), .pod_in_reset_o(pir_a), .busy_o(busy_a));
  bsg_manycore_pod_reset_sequencer #(.num_pods_x_p(2), .num_pods_y_p(2), .num_tiles_x_p(4),
    .reset_depth_p(1), .stagger_cycles_p(1)) u_b (.clk_i(clk), .reset_i(rst_in),
    .reset_req_i(req), .reset_o(ro_b), .pod_in_reset_o(pir_b), .busy_o(busy_b));

  typedef struct {logic r; logic [3:0] q; logic [3:0] pir; logic busy; logic [3:0] ro;} vec_t;
  vec_t tbl[18];
  int checks = 0, fails = 0, n = 0;
  int m_s[2] = '{4, 1};
  int m_d[2] = '{3, 1};
  int m_next[2];
  logic [3:0] m_rst[2];
  logic [3:0] m_hist[2][3];
  logic m_busy[2];

  function automatic logic [15:0] expand(input logic [3:0] v);
    logic [15:0] e;
    for (int p = 0; p < 4; p++) e[p*4 +: 4] = {4{v[p]}};
    return e;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: actual=%h required=%h", nm, n, act, exp);
    end
  endtask

  // Reference: a pod may be released at edge n only if n has reached the earliest
  // edge allowed by the previous release; reset_o is rst history delayed d-1 edges.
  task automatic step(input logic r, input logic [3:0] q);
    logic [3:0] nx;
    rst_in = r;
    req = q;
    for (int i = 0; i < 2; i++) begin
      nx = m_rst[i];
      if (r) begin
        nx = 4'hF;
        m_next[i] = 0;
        for (int k = 0; k < 3; k++) m_hist[i][k] = 4'hF;
      end else begin
        if (n >= m_next[i])
          for (int p = 0; p < 4; p++)
            if (m_rst[i][p] && !q[p]) begin
              nx[p] = 1'b0;
              m_next[i] = n + m_s[i];
              break;
            end
        nx |= q;
        for (int k = 2; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = nx;
      end
      m_rst[i] = nx;
      m_busy[i] = !r && (n < m_next[i] - 1);
    end
    @(posedge clk);
    #1;
    check("pir_a", 16'(pir_a), 16'(m_rst[0]));
    check("busy_a", 16'(busy_a), 16'(m_busy[0]));
    check("ro_a", ro_a, expand(m_hist[0][m_d[0]-1]));
    check("pir_b", 16'(pir_b), 16'(m_rst[1]));
    check("busy_b", 16'(busy_b), 16'(m_busy[1]));
    check("ro_b", ro_b, expand(m_hist[1][m_d[1]-1]));
    n++;
  endtask

  initial begin
    tbl[0]  = '{1, 4'h0, 4'hF, 0, 4'hF};
    tbl[1]  = '{1, 4'h0, 4'hF, 0, 4'hF};
    tbl[2]  = '{0, 4'h0, 4'hE, 1, 4'hF};
    tbl[3]  = '{0, 4'h0, 4'hE, 1, 4'hF};
    tbl[4]  = '{0, 4'h0, 4'hE, 1, 4'hE};
    tbl[5]  = '{0, 4'h0, 4'hE, 0, 4'hE};
    tbl[6]  = '{0, 4'h0, 4'hC, 1, 4'hE};
    tbl[7]  = '{0, 4'h0, 4'hC, 1, 4'hE};
    tbl[8]  = '{0, 4'h0, 4'hC, 1, 4'hC};
    tbl[9]  = '{0, 4'h0, 4'hC, 0, 4'hC};
    tbl[10] = '{0, 4'h0, 4'h8, 1, 4'hC};
    tbl[11] = '{0, 4'h0, 4'h8, 1, 4'hC};
    tbl[12] = '{0, 4'h0, 4'h8, 1, 4'h8};
    tbl[13] = '{0, 4'h0, 4'h8, 0, 4'h8};
    tbl[14] = '{0, 4'h0, 4'h0, 1, 4'h8};
    tbl[15] = '{0, 4'h0, 4'h0, 1, 4'h8};
    tbl[16] = '{0, 4'h0, 4'h0, 1, 4'h0};
    tbl[17] = '{0, 4'h0, 4'h0, 0, 4'h0};
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].q);
      check("tbl_pir", 16'(pir_a), 16'(tbl[i].pir));
      check("tbl_busy", 16'(busy_a), 16'(tbl[i].busy));
      check("tbl_ro", ro_a, expand(tbl[i].ro));
    end
    // Single-cycle re-request of pod 2 after full release.
    step(0, 4'b0100);
    check("rereq_pir", 16'(pir_a), 16'h4);
    step(0, 4'b0000);
    check("rereq_release", 16'(pir_a), 16'h0);
    step(0, 4'b0000);
    check("rereq_ro", ro_a, expand(4'h4));
    for (int i = 0; i < 6; i++) step(0, 4'b0000);
    // All held, then pods 3 and 1 drop together: pod 1 first, pod 3 four edges later.
    step(1, 4'hF);
    for (int i = 0; i < 5; i++) step(0, 4'hF);
    step(0, 4'b0101);
    check("drop_first", 16'(pir_a), 16'hD);
    for (int i = 0; i < 3; i++) step(0, 4'b0101);
    check("drop_gap", 16'(pir_a), 16'hD);
    step(0, 4'b0101);
    check("drop_second", 16'(pir_a), 16'h5);
    // Reset pulse mid-sequence restarts from pod 0.
    step(1, 4'h0);
    for (int i = 0; i < 6; i++) step(0, 4'h0);
    step(1, 4'h0);
    check("midrst_busy", 16'(busy_a), 16'h0);
    check("midrst_pir", 16'(pir_a), 16'hF);
    step(0, 4'h0);
    check("midrst_restart", 16'(pir_a), 16'hE);
    check("midrst_ro", ro_a, 16'hFFFF);
    for (int i = 0; i < 14; i++) step(0, 4'h0);
    // Pod 0 held: others still released, pod 0 stays in reset.
    step(1, 4'h0);
    for (int i = 0; i < 16; i++) step(0, 4'b0001);
    check("held_pir", 16'(pir_a), 16'h1);
    check("held_ro", ro_a, 16'h000F);
    check("held_pir_b", 16'(pir_b), 16'h1);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] q;
      for (int p = 0; p < 4; p++) q[p] = $urandom_range(0, 4) == 0;
      step($urandom_range(0, 39) == 0, q);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
